// File: rtl/codificador_pkg.sv
// Shared types and code-select constants for the 4-bit code converter.
package codificador_pkg;

  localparam int CODE_GRAY = 0;
  localparam int CODE_XS3  = 1;
  localparam int CODE_ONES = 2;
  localparam int CODE_BIN  = 3;

  typedef logic [3:0] nibble_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage : codificador_pkg

// File: rtl/codificador_4b_code_conv.sv
// Combinational nibble-to-code mapping, with the code fixed at elaboration.
module code_conv
  import codificador_pkg::*;
#(
  parameter int CODE = CODE_GRAY
) (
  input  nibble_t n,
  output nibble_t code
);

  generate
    if (CODE == CODE_GRAY) begin : g_gray
      assign code = n ^ (n >> 1);
    end else if (CODE == CODE_XS3) begin : g_xs3
      // Plain 4-bit add: the carry is dropped, so 13..15 wrap to 0..2.
      assign code = n + 4'd3;
    end else if (CODE == CODE_ONES) begin : g_ones
      assign code = ~n;
    end else if (CODE == CODE_BIN) begin : g_bin
      assign code = n;
    end else begin : g_bad_code
      $error("code_conv: CODE must be 0..3");
      assign code = '0;
    end
  endgenerate

endmodule : code_conv

// File: rtl/codificador_4b.sv
// 4-bit code converter: captures {A,B,C,D} on a rising ready edge and holds the
// selected code with a valid flag until ready drops.
module codificador_4b
  import codificador_pkg::*;
#(
  parameter int CODE = CODE_GRAY
) (
  input  logic clk,
  input  logic reset,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic ready,
  output logic S3,
  output logic S2,
  output logic S1,
  output logic S0,
  output logic valid
);

  state_e  state_q, state_d;
  logic    ready_q, ready_d;
  nibble_t n_q, n_d;
  nibble_t s_q, s_d;
  logic    valid_q, valid_d;
  nibble_t code_w;
  logic    request;

  code_conv #(.CODE(CODE)) u_conv (
    .n    (n_d),
    .code (code_w)
  );

  assign request = ready & ~ready_q;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path infers a latch.
    state_d = state_q;
    ready_d = ready;
    n_d     = n_q;
    s_d     = s_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (request) begin
          n_d     = {A, B, C, D};
          s_d     = code_w;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q <= IDLE;
      // Preset high so a ready already asserted at reset release is not an edge.
      ready_q <= 1'b1;
      n_q     <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      n_q     <= n_d;
      s_q     <= s_d;
      valid_q <= valid_d;
    end
  end

  assign {S3, S2, S1, S0} = s_q;
  assign valid            = valid_q;

endmodule : codificador_4b

// File: tb/tb_codificador_4b.sv
// Directed bench: four instances (one per CODE) share stimulus; table-driven
// conversions plus hand-written reset, hold and simultaneous-event sequences.
module tb_codificador_4b;
  import codificador_pkg::*;

  logic clk = 1'b0;
  logic reset, ready;
  nibble_t din;
  logic [3:0] s_o [4];
  logic       v_o [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  codificador_4b #(.CODE(CODE_GRAY)) u_gray (
    .clk(clk), .reset(reset), .A(din[3]), .B(din[2]), .C(din[1]), .D(din[0]),
    .ready(ready), .S3(s_o[0][3]), .S2(s_o[0][2]), .S1(s_o[0][1]), .S0(s_o[0][0]),
    .valid(v_o[0]));
  codificador_4b #(.CODE(CODE_XS3)) u_xs3 (
    .clk(clk), .reset(reset), .A(din[3]), .B(din[2]), .C(din[1]), .D(din[0]),
    .ready(ready), .S3(s_o[1][3]), .S2(s_o[1][2]), .S1(s_o[1][1]), .S0(s_o[1][0]),
    .valid(v_o[1]));
  codificador_4b #(.CODE(CODE_ONES)) u_ones (
    .clk(clk), .reset(reset), .A(din[3]), .B(din[2]), .C(din[1]), .D(din[0]),
    .ready(ready), .S3(s_o[2][3]), .S2(s_o[2][2]), .S1(s_o[2][1]), .S0(s_o[2][0]),
    .valid(v_o[2]));
  codificador_4b #(.CODE(CODE_BIN)) u_bin (
    .clk(clk), .reset(reset), .A(din[3]), .B(din[2]), .C(din[1]), .D(din[0]),
    .ready(ready), .S3(s_o[3][3]), .S2(s_o[3][2]), .S1(s_o[3][1]), .S0(s_o[3][0]),
    .valid(v_o[3]));

  typedef struct {
    nibble_t n;
    nibble_t gray;
    nibble_t xs3;
    nibble_t ones;
    nibble_t bin;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fresh request: reset pulse, ready low for a cycle, then raise ready with n.
  task automatic request(input nibble_t n);
    reset = 1'b0;
    step();
    reset = 1'b1;
    ready = 1'b0;
    step();
    din   = n;
    ready = 1'b1;
    step();
  endtask

  initial begin
    vecs[0] = '{n: 4'b0001, gray: 4'b0001, xs3: 4'b0100, ones: 4'b1110, bin: 4'b0001};
    vecs[1] = '{n: 4'b0101, gray: 4'b0111, xs3: 4'b1000, ones: 4'b1010, bin: 4'b0101};
    vecs[2] = '{n: 4'b1000, gray: 4'b1100, xs3: 4'b1011, ones: 4'b0111, bin: 4'b1000};
    vecs[3] = '{n: 4'b1111, gray: 4'b1000, xs3: 4'b0010, ones: 4'b0000, bin: 4'b1111};
    vecs[4] = '{n: 4'b0010, gray: 4'b0011, xs3: 4'b0101, ones: 4'b1101, bin: 4'b0010};
    vecs[5] = '{n: 4'b1101, gray: 4'b1011, xs3: 4'b0000, ones: 4'b0010, bin: 4'b1101};
    vecs[6] = '{n: 4'b1110, gray: 4'b1001, xs3: 4'b0001, ones: 4'b0001, bin: 4'b1110};
    vecs[7] = '{n: 4'b0011, gray: 4'b0010, xs3: 4'b0110, ones: 4'b1100, bin: 4'b0011};
    vecs[8] = '{n: 4'b0000, gray: 4'b0000, xs3: 4'b0011, ones: 4'b1111, bin: 4'b0000};
    vecs[9] = '{n: 4'b1010, gray: 4'b1111, xs3: 4'b1101, ones: 4'b0101, bin: 4'b1010};

    // Reset held with ready high and inputs all ones.
    reset = 1'b0;
    ready = 1'b1;
    din   = 4'b1111;
    step();
    step();
    check("reset_s_gray", s_o[0], 4'b0000);
    check("reset_s_ones", s_o[2], 4'b0000);
    check("reset_valid", {3'b0, v_o[0]}, 4'b0000);
    reset = 1'b1;
    step();
    step();
    check("release_ready_high_valid", {3'b0, v_o[0]}, 4'b0000);
    check("release_ready_high_s", s_o[3], 4'b0000);

    foreach (vecs[i]) begin
      request(vecs[i].n);
      check($sformatf("gray_n%b", vecs[i].n), s_o[0], vecs[i].gray);
      check($sformatf("xs3_n%b", vecs[i].n), s_o[1], vecs[i].xs3);
      check($sformatf("ones_n%b", vecs[i].n), s_o[2], vecs[i].ones);
      check($sformatf("bin_n%b", vecs[i].n), s_o[3], vecs[i].bin);
      check($sformatf("valid_n%b", vecs[i].n), {v_o[3], v_o[2], v_o[1], v_o[0]}, 4'b1111);
    end

    // Hold: input changes ignored while ready stays high.
    request(4'b0101);
    din = 4'b1010;
    step();
    step();
    check("hold_s", s_o[0], 4'b0111);
    check("hold_valid", {3'b0, v_o[0]}, 4'b0001);
    ready = 1'b0;
    step();
    check("drop_valid", {3'b0, v_o[0]}, 4'b0000);
    check("drop_s_kept", s_o[0], 4'b0111);
    check("drop_xs3_kept", s_o[1], 4'b1000);

    // Reset in HOLD clears outputs, then a new request works.
    request(4'b1000);
    check("mid_pre_s", s_o[0], 4'b1100);
    reset = 1'b0;
    step();
    check("mid_reset_s", s_o[0], 4'b0000);
    check("mid_reset_valid", {3'b0, v_o[0]}, 4'b0000);
    reset = 1'b1;
    ready = 1'b0;
    step();
    din   = 4'b0011;
    ready = 1'b1;
    step();
    check("after_mid_s", s_o[0], 4'b0010);
    check("after_mid_valid", {3'b0, v_o[0]}, 4'b0001);

    // Reset coincident with a ready rise: no capture, none after release either.
    ready = 1'b0;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    din   = 4'b1111;
    reset = 1'b0;
    ready = 1'b1;
    step();
    check("simul_s", s_o[0], 4'b0000);
    check("simul_valid", {3'b0, v_o[0]}, 4'b0000);
    reset = 1'b1;
    step();
    check("simul_after_valid", {3'b0, v_o[0]}, 4'b0000);
    check("simul_after_s", s_o[2], 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_codificador_4b

// File: doc/codificador_4b.md
Name: codificador_4b

Overview:
- 4-bit code converter for the coding-system datapath.
- Samples a 4-bit binary value (A = MSB … D = LSB) when `ready` rises.
- Converts the value to the selected output code and presents it registered on S3..S0 (S3 = MSB), with a valid flag.
- Sits between the operand-input stage and the display/check stage; one instance per 4-bit digit.

Parameters:
- CODE, 0, output code select: 0 = binary-to-Gray, 1 = Excess-3 (value+3 mod 16), 2 = one's complement, 3 = pass-through binary.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- A  input  1  data bit 3 (MSB).
- B  input  1  data bit 2.
- C  input  1  data bit 1.
- D  input  1  data bit 0 (LSB).
- ready  input  1  request level; a 0→1 transition requests one conversion.
- S3  output  1  code bit 3 (MSB).
- S2  output  1  code bit 2.
- S1  output  1  code bit 1.
- S0  output  1  code bit 0 (LSB).
- valid  output  1  high while S3..S0 holds the code of the current request.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (reset = 0 at a clk rising edge resets the block).
- Reset values: S3..S0 = 0000, valid = 0, state = IDLE, ready_q (previous-ready register) = 1. Setting ready_q to 1 means a ready already high when reset releases is not treated as a request.
- Reset has priority over every other event, including a ready edge in the same cycle; a reset mid-request drops the request.
- ready_q registers ready every cycle. A request is a rising edge: ready = 1 and ready_q = 0 at a clk edge.
- States:
  - IDLE: waits for a request. On a request, captures N = {A,B,C,D} into an internal register, goes to HOLD, and updates S3..S0 with code(N) and sets valid = 1 at that same edge. Latency is 1 cycle from the sampling edge; outputs are fully registered with no combinational path from inputs to outputs.
  - HOLD: S3..S0 and valid stay constant while ready = 1; changes on A..D are ignored. When ready = 0 at an edge: valid → 0, S3..S0 keep the last code, state → IDLE.
  - A request is only recognised in IDLE. A rising edge on the same edge that leaves HOLD is impossible, because ready must be 0 to leave.
- Code functions on a 4-bit N, with output S = {S3,S2,S1,S0}:
  - Gray: S3 = A; S2 = A^B; S1 = B^C; S0 = C^D.
  - Excess-3: S = (N + 3) mod 16; wraps, so 13 → 0000, 14 → 0001, 15 → 0010; no carry output.
  - One's complement: S = ~N.
  - Pass-through: S = N.
- An invalid CODE value is a elaboration-time error (generate-time assertion).

Decomposition:
- Shared package `codificador_pkg`:
  - localparams CODE_GRAY = 0, CODE_XS3 = 1, CODE_ONES = 2, CODE_BIN = 3;
  - a 4-bit nibble typedef;
  - the state enum {IDLE, HOLD}.
- Sub-module `code_conv` (purely combinational; inputs: 4-bit N and the CODE parameter; output: 4-bit code).
- Top `codificador_4b` contains the edge detector, FSM, capture register and output register.

Test Plan:
- Reset: hold reset = 0 for 2 cycles with ready = 1, A..D = 1111 → S = 0000, valid = 0. Release reset with ready still 1 → no conversion; valid stays 0.
- Gray sweep (CODE = 0): for N = 1..15, each time reset pulse 0, ready 0 for 1 cycle, apply N, ready 1. Expected, 1 cycle after the rising edge:
  - N = 1 → 0001, valid = 1
  - N = 5 → 0111
  - N = 8 → 1100
  - N = 15 → 1000
- Hold: after the request with N = 0101 (S = 0111), change A..D to 1010 while ready = 1 → S stays 0111. Drop ready → valid = 0, S stays 0111.
- Excess-3 wrap (CODE = 1):
  - N = 0010 → 0101
  - N = 1101 → 0000
  - N = 1111 → 0010
- Reset mid-operation: in HOLD with S = 1100, pull reset = 0 for 1 cycle → next cycle S = 0000, valid = 0, state = IDLE. Then raise ready with N = 0011 (after it has been low) → S = 0010 (Gray).
- Simultaneous events: reset = 0 on the same edge as a ready rise → no capture; outputs stay 0000 / 0.
